// File: rtl/burst_bus_arbiter.sv
// Two-master burst arbiter in front of a single PSRAM burst port.
// Whole bursts are granted; write beats come from the owner and read beats are returned only to the owner.
module burst_bus_arbiter #(
  parameter int unsigned BURST_BEATS = 4,
  parameter int unsigned CMD_GAP     = 2,
  parameter bit          ROUND_ROBIN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  // requester 0
  input  logic        m0_cmd_en,
  input  logic        m0_cmd,
  input  logic [21:0] m0_addr,
  input  logic [63:0] m0_wr_data,
  input  logic [7:0]  m0_data_mask,
  output logic        m0_ready,
  output logic [63:0] m0_rd_data,
  output logic        m0_rd_data_valid,
  // requester 1
  input  logic        m1_cmd_en,
  input  logic        m1_cmd,
  input  logic [21:0] m1_addr,
  input  logic [63:0] m1_wr_data,
  input  logic [7:0]  m1_data_mask,
  output logic        m1_ready,
  output logic [63:0] m1_rd_data,
  output logic        m1_rd_data_valid,
  // PSRAM controller
  output logic        mem_cmd_en,
  output logic        mem_cmd,
  output logic [21:0] mem_addr,
  output logic [63:0] mem_wr_data,
  output logic [7:0]  mem_data_mask,
  input  logic        mem_ready,
  input  logic [63:0] mem_rd_data,
  input  logic        mem_rd_data_valid
);

  localparam int unsigned BW = $clog2(BURST_BEATS + 1);
  localparam int unsigned GW = (CMD_GAP > 0) ? $clog2(CMD_GAP + 1) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_BEATS - 1);
  localparam logic [GW-1:0] LAST_GAP  = GW'((CMD_GAP > 0) ? CMD_GAP - 1 : 0);
  // With no gap configured a finished burst goes straight back to IDLE.
  localparam logic [2:0]    S_AFTER   = (CMD_GAP > 0) ? S_GAP : S_IDLE;

  logic [2:0]    state;
  logic          owner;
  logic          last_owner;
  logic [BW-1:0] beat_cnt;
  logic [GW-1:0] gap_cnt;
  logic          pick_m1;
  logic          data_phase;
  logic          rd_phase;

  always_comb begin
    pick_m1 = m1_cmd_en;
    if (m0_cmd_en && m1_cmd_en) begin
      pick_m1 = ROUND_ROBIN ? !last_owner : 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      beat_cnt   <= '0;
      gap_cnt    <= '0;
      mem_addr   <= '0;
      mem_cmd    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_ready && (m0_cmd_en || m1_cmd_en)) begin
            owner    <= pick_m1;
            mem_addr <= pick_m1 ? m1_addr : m0_addr;
            mem_cmd  <= pick_m1 ? m1_cmd : m0_cmd;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          last_owner <= owner;
          beat_cnt   <= '0;
          gap_cnt    <= '0;
          if (!mem_cmd) begin
            state <= S_READ;
          end else if (BURST_BEATS == 1) begin
            state <= S_AFTER;
          end else begin
            state    <= S_WRITE;
            beat_cnt <= BW'(1);
          end
        end
        S_WRITE: begin
          if (beat_cnt == LAST_BEAT) begin
            state    <= S_AFTER;
            beat_cnt <= '0;
          end else begin
            beat_cnt <= beat_cnt + BW'(1);
          end
        end
        S_READ: begin
          if (mem_rd_data_valid) begin
            if (beat_cnt == LAST_BEAT) begin
              state    <= S_AFTER;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + BW'(1);
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == LAST_GAP) begin
            state   <= S_IDLE;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Beat 0 rides with the command; later write beats are taken live from the owner.
  assign data_phase    = (state == S_ISSUE) || (state == S_WRITE);
  assign rd_phase      = (state == S_READ) && mem_rd_data_valid;

  assign mem_cmd_en    = (state == S_ISSUE);
  assign mem_wr_data   = data_phase ? (owner ? m1_wr_data : m0_wr_data) : '0;
  assign mem_data_mask = data_phase ? (owner ? m1_data_mask : m0_data_mask) : '0;

  assign m0_ready         = (state == S_ISSUE) && !owner;
  assign m1_ready         = (state == S_ISSUE) && owner;
  assign m0_rd_data       = mem_rd_data;
  assign m1_rd_data       = mem_rd_data;
  assign m0_rd_data_valid = rd_phase && !owner;
  assign m1_rd_data_valid = rd_phase && owner;

endmodule
